// File: rtl/tile_row_sequencer.sv
// Purpose: turn controller for one row of tiles; passes a one-cycle myturn token forward/backward.
// Latency: start -> myturn[0] next cycle; strobe -> next myturn next cycle; watchdog FAIL TIMEOUT cycles after GRANT.
// Backpressure: none; each tile holds the row in WAIT until it strobes passfwd/passbak or the watchdog expires.
//
// Ports:
//   clock, reset (async active-low), start      - control
//   passfwd/passbak [LEN]                       - per-tile advance / backtrack strobes (only curidx is sampled)
//   values [LEN*LEN]                            - one-hot value of tile i at [i*LEN +: LEN]
//   myturn, occupiedmask, curidx                - token, OR of values before curidx, current index
//   busy, done, fail, timedout, backtracks      - status to the grid controller
`ifndef GRID_LEN
`define GRID_LEN 9
`endif

module tile_row_sequencer #(
    parameter int LEN     = `GRID_LEN,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [LEN-1:0]         passfwd,
    input  logic [LEN-1:0]         passbak,
    input  logic [LEN*LEN-1:0]     values,
    output logic [LEN-1:0]         myturn,
    output logic [LEN-1:0]         occupiedmask,
    output logic [$clog2(LEN)-1:0] curidx,
    output logic                   busy,
    output logic                   done,
    output logic                   fail,
    output logic                   timedout,
    output logic [15:0]            backtracks
);

    localparam int IW = $clog2(LEN);
    localparam int WW = $clog2(TIMEOUT) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(LEN - 1);
    // WAIT lasts TIMEOUT-1 cycles, so with the GRANT cycle FAIL appears TIMEOUT cycles after the grant.
    localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_WAIT,
        S_DONE,
        S_FAIL
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [15:0]     bt_q, bt_d;
    logic [WW-1:0]   wd_q, wd_d;
    logic            to_q, to_d;
    logic [WW-1:0]   wd_inc;
    logic            cur_fwd, cur_bak;

    // Only the tile holding the turn is listened to.
    assign cur_fwd = passfwd[idx_q];
    assign cur_bak = passbak[idx_q];
    assign wd_inc  = wd_q + 1'b1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        bt_d    = bt_q;
        wd_d    = wd_q;
        to_d    = to_q;
        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start) begin
                    state_d = S_GRANT;
                    idx_d   = '0;
                    bt_d    = '0;
                    wd_d    = '0;
                    to_d    = 1'b0;
                end
            end
            S_GRANT: begin
                state_d = S_WAIT;
                wd_d    = '0;
            end
            S_WAIT: begin
                if (cur_bak) begin
                    if (idx_q == '0) begin
                        state_d = S_FAIL;
                        to_d    = 1'b0;
                    end else begin
                        state_d = S_GRANT;
                        idx_d   = idx_q - 1'b1;
                        if (bt_q != 16'hFFFF) begin
                            bt_d = bt_q + 16'd1;
                        end
                    end
                end else if (cur_fwd) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_GRANT;
                        idx_d   = idx_q + 1'b1;
                    end
                end else begin
                    wd_d = wd_inc;
                    if (wd_inc == WD_LIMIT) begin
                        state_d = S_FAIL;
                        to_d    = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            bt_q    <= '0;
            wd_q    <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            bt_q    <= bt_d;
            wd_q    <= wd_d;
            to_q    <= to_d;
        end
    end

    // Status outputs depend on registered state only.
    assign myturn     = (state_q == S_GRANT) ? (LEN'(1) << idx_q) : '0;
    assign busy       = (state_q == S_GRANT) || (state_q == S_WAIT);
    assign done       = (state_q == S_DONE);
    assign fail       = (state_q == S_FAIL);
    assign curidx     = idx_q;
    assign timedout   = to_q;
    assign backtracks = bt_q;

    always_comb begin
        occupiedmask = '0;
        for (int i = 0; i < LEN; i++) begin
            if (i < int'(idx_q)) begin
                occupiedmask = occupiedmask | values[i*LEN +: LEN];
            end
        end
    end

endmodule

// File: tb/tb_tile_row_sequencer.sv
// Purpose: self-checking bench for tile_row_sequencer (LEN=4, TIMEOUT=16).
// Latency: n/a (bench).
// Backpressure: n/a (bench); a tile agent answers each turn after a programmable delay.
module tb_tile_row_sequencer;

    localparam int LEN = 4;
    localparam int TO  = 16;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic                 start = 1'b0;
    logic [LEN-1:0]       passfwd = '0;
    logic [LEN-1:0]       passbak = '0;
    logic [LEN*LEN-1:0]   values = '0;
    logic [LEN-1:0]       myturn, occupiedmask;
    logic [1:0]           curidx;
    logic                 busy, done, fail, timedout;
    logic [15:0]          backtracks;

    tile_row_sequencer #(.LEN(LEN), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .start(start),
        .passfwd(passfwd), .passbak(passbak), .values(values),
        .myturn(myturn), .occupiedmask(occupiedmask), .curidx(curidx),
        .busy(busy), .done(done), .fail(fail), .timedout(timedout),
        .backtracks(backtracks)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- tile agent ----------------
    // Actions per turn: 0 advance, 1 backtrack, 2 both strobes, 3 never answer.
    int             script[$];
    int             turn_log[$];
    bit             start_req = 0;
    bit             noise_en = 0;
    bit             rand_vals = 0;
    int             dmin = 2, dmax = 2, bak_pct = 0;
    logic [LEN-1:0] extra_fwd = '0;
    int             pend = 0, cnt = 0, act = 0;

    initial forever begin
        logic [LEN-1:0] msk, nz;
        @(posedge clock);
        #1;
        start   = 1'b0;
        passbak = '0;
        passfwd = extra_fwd;
        extra_fwd = '0;
        if (start_req) begin
            start = 1'b1;
            start_req = 0;
        end
        if (!reset) cnt = 0;
        if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                if (act == 0 || act == 2) passfwd[pend] = 1'b1;
                if (act == 1 || act == 2) passbak[pend] = 1'b1;
            end
        end
        if (reset && myturn != '0) begin
            for (int i = 0; i < LEN; i++) if (myturn[i]) pend = i;
            turn_log.push_back(pend);
            if (script.size() > 0) act = script.pop_front();
            else act = ($urandom_range(99) < bak_pct) ? 1 : 0;
            cnt = (act == 3) ? 0 : int'($urandom_range(dmax, dmin));
        end
        if (noise_en) begin
            msk = ~(LEN'(1) << pend);
            nz = LEN'($urandom());
            passfwd = passfwd | (nz & msk);
            nz = LEN'($urandom());
            passbak = passbak | (nz & msk);
        end
        if (rand_vals) begin
            for (int t = 0; t < LEN; t++)
                values[t*LEN +: LEN] = ($urandom_range(4) == 0) ? '0 : (LEN'(1) << $urandom_range(LEN-1));
        end
    end

    // ---------------- behavioural model ----------------
    bit m_run, m_grant, m_done, m_fail, m_to;
    int m_idx, m_bt, m_wait;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_run = 0; m_grant = 0; m_done = 0; m_fail = 0; m_to = 0;
            m_idx = 0; m_bt = 0; m_wait = 0;
        end else if (m_grant) begin
            m_grant = 0;
            m_wait = 0;
        end else if (m_run) begin
            if (passbak[m_idx]) begin
                if (m_idx == 0) begin
                    m_run = 0; m_fail = 1; m_to = 0;
                end else begin
                    m_idx = m_idx - 1;
                    if (m_bt < 65535) m_bt = m_bt + 1;
                    m_grant = 1;
                end
            end else if (passfwd[m_idx]) begin
                if (m_idx == LEN - 1) begin
                    m_run = 0; m_done = 1;
                end else begin
                    m_idx = m_idx + 1;
                    m_grant = 1;
                end
            end else begin
                m_wait = m_wait + 1;
                if (m_wait == TO - 1) begin
                    m_run = 0; m_fail = 1; m_to = 1;
                end
            end
        end else if (start) begin
            m_run = 1; m_grant = 1; m_done = 0; m_fail = 0; m_to = 0;
            m_idx = 0; m_bt = 0; m_wait = 0;
        end
    end

    always @(negedge clock) begin
        logic [LEN-1:0] e_turn, e_occ;
        if (reset) begin
            e_turn = '0;
            if (m_grant) e_turn[m_idx] = 1'b1;
            e_occ = '0;
            for (int i = 0; i < m_idx; i++) e_occ = e_occ | values[i*LEN +: LEN];
            chk("myturn", myturn, e_turn);
            chk("curidx", curidx, m_idx);
            chk("busy", busy, m_run);
            chk("done", done, m_done);
            chk("fail", fail, m_fail);
            chk("timedout", timedout, m_to);
            chk("backtracks", backtracks, m_bt);
            chk("occupiedmask", occupiedmask, e_occ);
        end
    end

    // ---------------- directed + random sequences ----------------
    logic [3:0] occ2;

    function automatic logic [31:0] pack_log();
        logic [31:0] p = '0;
        foreach (turn_log[i]) p = (p << 4) | 32'(turn_log[i]);
        return p;
    endfunction

    task automatic begin_row();
        turn_log.delete();
        start_req = 1;
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic run_row(input int bound);
        int c = 0;
        begin_row();
        while (!(done || fail) && c < bound) begin
            if (curidx == 2 && busy) occ2 = occupiedmask;
            @(negedge clock);
            c++;
        end
        chk("row_finished", 64'(done || fail), 1);
    endtask

    initial begin
        int c;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_myturn", myturn, 0);
        chk("rst_curidx", curidx, 0);
        chk("rst_backtracks", backtracks, 0);
        chk("rst_status", {busy, done, fail, timedout}, 0);
        chk("rst_occ", occupiedmask, 0);
        repeat (4) begin
            extra_fwd = 4'b1111;
            @(negedge clock);
        end
        chk("idle_no_turn", {myturn, busy}, 0);

        // Straight fill.
        values = 16'h0041;
        script = '{0, 0, 0, 0};
        run_row(100);
        chk("fill_order", pack_log(), 32'h0123);
        chk("fill_len", turn_log.size(), 4);
        chk("fill_done", {done, fail}, 2'b10);
        chk("fill_bt", backtracks, 0);
        chk("fill_occ2", occ2, 4'b0101);

        // Backtrack chain.
        script = '{0, 0, 1, 0, 0, 0};
        run_row(100);
        chk("chain_order", pack_log(), 32'h012123);
        chk("chain_done", done, 1);
        chk("chain_bt", backtracks, 1);

        // Row failure.
        script = '{1};
        run_row(100);
        chk("rowfail_flags", {fail, timedout}, 2'b10);
        chk("rowfail_idx_bt", {curidx, backtracks}, 0);

        // Filtering of other tiles' strobes, then the watchdog releases the row.
        script = '{0, 3};
        begin_row();
        c = 0;
        while (!(curidx == 1 && busy) && c < 50) begin @(negedge clock); c++; end
        repeat (2) @(negedge clock);
        extra_fwd = 4'b1000;
        repeat (3) @(negedge clock);
        chk("filter_idx", curidx, 1);
        chk("filter_busy", busy, 1);
        c = 0;
        while (!fail && c < 50) begin @(negedge clock); c++; end
        chk("filter_wd_fail", {fail, timedout}, 2'b11);

        // Backtrack beats advance when both are raised.
        script = '{0, 2, 1};
        run_row(100);
        chk("prio_order", pack_log(), 32'h010);
        chk("prio_bt", backtracks, 1);
        chk("prio_fail", {fail, timedout, curidx}, 4'b1000);

        // Watchdog timing, then restart.
        script = '{3};
        begin_row();
        chk("wd_grant", myturn, 4'b0001);
        chk("wd_bt_cleared", backtracks, 0);
        c = 0;
        while (!fail && c < 40) begin @(negedge clock); c++; end
        chk("wd_cycles", c, 16);
        chk("wd_flags", {fail, timedout}, 2'b11);
        script = '{1};
        begin_row();
        chk("restart_turn", myturn, 4'b0001);
        chk("restart_to", timedout, 0);
        chk("restart_bt", backtracks, 0);
        c = 0;
        while (!fail && c < 40) begin @(negedge clock); c++; end

        // Reset in the middle of a grant drops the token at once.
        script = '{0, 0};
        begin_row();
        c = 0;
        while (!(myturn == 4'b0100) && c < 50) begin @(negedge clock); c++; end
        #1 reset = 1'b0;
        #1;
        chk("async_rst_turn", myturn, 0);
        chk("async_rst_state", {busy, curidx}, 0);
        @(negedge clock);
        script.delete();
        reset = 1'b1;
        @(negedge clock);

        // Randomized rows with noise on other tiles and random values.
        noise_en = 1; rand_vals = 1; dmin = 1; dmax = 4; bak_pct = 30;
        for (int r = 0; r < 25; r++) run_row(3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation still running, expected to finish");
        $fatal(1);
    end

endmodule
